// File: rtl/fir_out_checker.sv
// fir_out_checker
//
// Compares a filter's output stream against a golden stream of expected
// samples. Expected samples are queued in a small FIFO (EVIN/EDIN). Each
// filter output (VIN/DIN) pops one expected sample and is scored as a match
// when |DIN - EDIN| <= TOL, otherwise as a mismatch. A run is started by a
// single-cycle START pulse and ends after NSAMP outputs have been checked.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      single-cycle pulse, begins a check run (restarts from any state)
//   nsamp      number of filter outputs to check, sampled on start
//   vin, din   filter output valid / sample (no backpressure)
//   evin, edin expected-sample valid / sample
//   efull      expected-sample FIFO full
//   busy       high while a run is in progress
//   done       high once the run has completed (level, until start or rst)
//   match_cnt  compares within tolerance (saturating)
//   mism_cnt   compares outside tolerance plus underflows (saturating)
//   first_err  0-based index of the first mismatch, 16'hFFFF if none
//   ovf        sticky: an expected sample was dropped on a full FIFO
//   unf        sticky: a filter output arrived with the FIFO empty

module fir_out_checker #(
  parameter int W     = 11,
  parameter int DEPTH = 16,
  parameter int TOL   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   nsamp,
  input  logic          vin,
  input  logic [W-1:0]  din,
  input  logic          evin,
  input  logic [W-1:0]  edin,
  output logic          efull,
  output logic          busy,
  output logic          done,
  output logic [15:0]   match_cnt,
  output logic [15:0]   mism_cnt,
  output logic [15:0]   first_err,
  output logic          ovf,
  output logic          unf
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [W:0]    TOL_C   = (W+1)'(TOL);
  localparam logic [15:0]   NONE_C  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Magnitude of a - b after sign extension to W+1 bits; the extra bit keeps
  // the extreme case (-2^(W-1)) - (2^(W-1)-1) from wrapping.
  function automatic logic [W:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {a[W-1], a} - {b[W-1], b};
    if (d[W]) begin
      abs_diff = -d;
    end else begin
      abs_diff = d;
    end
  endfunction

  state_t         state_r, next_state_s;
  logic [W-1:0]   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [AW:0]    cnt_r, cnt_next_s;
  logic [15:0]    target_r;
  logic [15:0]    match_cnt_r, mism_cnt_r, first_err_r;
  logic           ovf_r, unf_r;
  logic           busy_s, done_s;

  logic           run_s, push_req_s, pop_req_s, empty_s, full_s;
  logic           pop_s, push_s, drop_s, unf_ev_s, hit_s, miss_s, finish_s;
  logic [W-1:0]   head_s;
  logic [W:0]     mag_s;
  logic [16:0]    checked_s;

  // Datapath decode: FIFO handshakes, compare result, end-of-run detect.
  // A start in the same cycle wins over any data, so data is gated by it.
  always_comb begin
    run_s      = (state_r == ST_RUN) && !start;
    push_req_s = evin && run_s;
    pop_req_s  = vin && run_s;
    empty_s    = (cnt_r == '0);
    full_s     = (cnt_r == DEPTH_C);
    pop_s      = pop_req_s && !empty_s;
    unf_ev_s   = pop_req_s && empty_s;
    // A push on a full FIFO is still accepted when a pop frees a slot.
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
    head_s     = mem_r[rd_ptr_r];
    mag_s      = abs_diff(din, head_s);
    hit_s      = pop_s && (mag_s <= TOL_C);
    miss_s     = (pop_s && (mag_s > TOL_C)) || unf_ev_s;
    checked_s  = {1'b0, match_cnt_r} + {1'b0, mism_cnt_r};
    finish_s   = pop_req_s && ((checked_s + 17'd1) >= {1'b0, target_r});
    if (push_s && !pop_s) begin
      cnt_next_s = cnt_r + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      cnt_next_s = cnt_r - (AW+1)'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; start restarts a run from any state.
  always_comb begin
    next_state_s = state_r;
    if (start) begin
      if (nsamp == 16'd0) begin
        next_state_s = ST_DONE;
      end else begin
        next_state_s = ST_RUN;
      end
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = ST_IDLE;
        ST_RUN: begin
          if (finish_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_DONE: next_state_s = ST_DONE;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode, purely from the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= edin;
    end
  end

  // FIFO pointers, counters, first-error index and sticky flags.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      match_cnt_r <= 16'd0;
      mism_cnt_r  <= 16'd0;
      first_err_r <= NONE_C;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      // rst has priority: the target is only taken from a start without rst.
      target_r    <= rst ? 16'd0 : nsamp;
    end else begin
      cnt_r <= cnt_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (hit_s && (match_cnt_r != 16'hFFFF)) begin
        match_cnt_r <= match_cnt_r + 16'd1;
      end
      if (miss_s && (mism_cnt_r != 16'hFFFF)) begin
        mism_cnt_r <= mism_cnt_r + 16'd1;
      end
      if (miss_s && (first_err_r == NONE_C)) begin
        first_err_r <= checked_s[15:0];
      end
      if (unf_ev_s) begin
        unf_r <= 1'b1;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign efull     = (cnt_r == DEPTH_C);
  assign busy      = busy_s;
  assign done      = done_s;
  assign match_cnt = match_cnt_r;
  assign mism_cnt  = mism_cnt_r;
  assign first_err = first_err_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule

// File: tb/tb_fir_out_checker.sv
// Directed testbench for fir_out_checker. Two instances share all inputs:
// dut_a uses TOL=0, dut_b uses TOL=1. Inputs change and outputs are sampled
// on the falling edge of the clock.
module tb_fir_out_checker;

  logic        clk, rst, start, vin, evin;
  logic [15:0] nsamp;
  logic [10:0] din, edin;

  logic        efull_a, busy_a, done_a, ovf_a, unf_a;
  logic [15:0] match_a, mism_a, ferr_a;
  logic        efull_b, busy_b, done_b, ovf_b, unf_b;
  logic [15:0] match_b, mism_b, ferr_b;

  int total = 0;
  int bad   = 0;

  fir_out_checker #(.W(11), .DEPTH(16), .TOL(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .nsamp(nsamp), .vin(vin), .din(din),
    .evin(evin), .edin(edin), .efull(efull_a), .busy(busy_a), .done(done_a),
    .match_cnt(match_a), .mism_cnt(mism_a), .first_err(ferr_a), .ovf(ovf_a), .unf(unf_a));

  fir_out_checker #(.W(11), .DEPTH(16), .TOL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .nsamp(nsamp), .vin(vin), .din(din),
    .evin(evin), .edin(edin), .efull(efull_b), .busy(busy_b), .done(done_b),
    .match_cnt(match_b), .mism_cnt(mism_b), .first_err(ferr_b), .ovf(ovf_b), .unf(unf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; vin = 1'b0; evin = 1'b0; din = 11'd0; edin = 11'd0; nsamp = 16'd0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; nsamp = n; tick(); start = 1'b0;
  endtask

  task automatic push(input logic [10:0] v);
    evin = 1'b1; edin = v; tick(); evin = 1'b0;
  endtask

  task automatic pop(input logic [10:0] v);
    vin = 1'b1; din = v; tick(); vin = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a); end total++;
    if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done_a); end total++;
    if (efull_a !== 1'b0) begin bad++; $display("FAIL rst_efull got=%b exp=0", efull_a); end total++;
    if (match_a !== 16'd0) begin bad++; $display("FAIL rst_match got=%0d exp=0", match_a); end total++;
    if (mism_a !== 16'd0) begin bad++; $display("FAIL rst_mism got=%0d exp=0", mism_a); end total++;
    if (ferr_a !== 16'hFFFF) begin bad++; $display("FAIL rst_ferr got=%h exp=ffff", ferr_a); end total++;
    if ({ovf_a, unf_a} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {ovf_a, unf_a}); end total++;
  endtask

  task automatic test_basic();
    do_start(16'd4);
    if (busy_a !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy_a); end total++;
    push(11'd10); push(11'h7FD); push(11'd7); push(11'd0);
    pop(11'd10); pop(11'h7FD); pop(11'd7);
    if (done_a !== 1'b0) begin bad++; $display("FAIL basic_early_done got=%b exp=0", done_a); end total++;
    if (match_a !== 16'd3) begin bad++; $display("FAIL basic_match3 got=%0d exp=3", match_a); end total++;
    pop(11'd0);
    if (match_a !== 16'd4) begin bad++; $display("FAIL basic_match got=%0d exp=4", match_a); end total++;
    if (mism_a !== 16'd0) begin bad++; $display("FAIL basic_mism got=%0d exp=0", mism_a); end total++;
    if (ferr_a !== 16'hFFFF) begin bad++; $display("FAIL basic_ferr got=%h exp=ffff", ferr_a); end total++;
    if ({done_a, busy_a} !== 2'b10) begin bad++; $display("FAIL basic_done got=%b exp=10", {done_a, busy_a}); end total++;
    pop(11'd5);
    if (mism_a !== 16'd0) begin bad++; $display("FAIL basic_ignored_in_done got=%0d exp=0", mism_a); end total++;
  endtask

  task automatic test_tolerance();
    do_start(16'd3);
    push(11'd5); push(11'd5); push(11'd5);
    pop(11'd6); pop(11'd4); pop(11'd8);
    if (match_b !== 16'd2) begin bad++; $display("FAIL tol1_match got=%0d exp=2", match_b); end total++;
    if (mism_b !== 16'd1) begin bad++; $display("FAIL tol1_mism got=%0d exp=1", mism_b); end total++;
    if (ferr_b !== 16'd2) begin bad++; $display("FAIL tol1_ferr got=%0d exp=2", ferr_b); end total++;
    if (done_b !== 1'b1) begin bad++; $display("FAIL tol1_done got=%b exp=1", done_b); end total++;
    if (match_a !== 16'd0) begin bad++; $display("FAIL tol0_match got=%0d exp=0", match_a); end total++;
    if (mism_a !== 16'd3) begin bad++; $display("FAIL tol0_mism got=%0d exp=3", mism_a); end total++;
    if (ferr_a !== 16'd0) begin bad++; $display("FAIL tol0_ferr got=%0d exp=0", ferr_a); end total++;
  endtask

  task automatic test_overflow();
    do_start(16'd17);
    for (int i = 0; i < 17; i++) begin
      push(11'(i));
      if (i == 14 && efull_a !== 1'b0) begin bad++; $display("FAIL ovf_efull15 got=%b exp=0", efull_a); end
      if (i == 15 && {efull_a, ovf_a} !== 2'b10) begin bad++; $display("FAIL ovf_full16 got=%b exp=10", {efull_a, ovf_a}); end
      if (i == 16 && {efull_a, ovf_a} !== 2'b11) begin bad++; $display("FAIL ovf_drop17 got=%b exp=11", {efull_a, ovf_a}); end
      if (i >= 14) total++;
    end
    evin = 1'b1; edin = 11'd100; vin = 1'b1; din = 11'd0; tick(); evin = 1'b0; vin = 1'b0;
    if ({efull_a, ovf_a} !== 2'b11) begin bad++; $display("FAIL ovf_pushpop got=%b exp=11", {efull_a, ovf_a}); end total++;
    if (match_a !== 16'd1) begin bad++; $display("FAIL ovf_pushpop_match got=%0d exp=1", match_a); end total++;
    for (int i = 1; i < 16; i++) pop(11'(i));
    pop(11'd100);
    if (match_a !== 16'd17) begin bad++; $display("FAIL ovf_drain_match got=%0d exp=17", match_a); end total++;
    if (mism_a !== 16'd0) begin bad++; $display("FAIL ovf_drain_mism got=%0d exp=0", mism_a); end total++;
    if ({done_a, efull_a} !== 2'b10) begin bad++; $display("FAIL ovf_drain_done got=%b exp=10", {done_a, efull_a}); end total++;
  endtask

  task automatic test_underflow();
    do_start(16'd3);
    pop(11'd5);
    if (unf_a !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", unf_a); end total++;
    if (mism_a !== 16'd1) begin bad++; $display("FAIL unf_mism got=%0d exp=1", mism_a); end total++;
    if (ferr_a !== 16'd0) begin bad++; $display("FAIL unf_ferr got=%0d exp=0", ferr_a); end total++;
    evin = 1'b1; edin = 11'd7; vin = 1'b1; din = 11'd7; tick(); evin = 1'b0; vin = 1'b0;
    if (mism_a !== 16'd2) begin bad++; $display("FAIL unf_pushpop_mism got=%0d exp=2", mism_a); end total++;
    if (ferr_a !== 16'd0) begin bad++; $display("FAIL unf_ferr_kept got=%0d exp=0", ferr_a); end total++;
    pop(11'd7);
    if (match_a !== 16'd1) begin bad++; $display("FAIL unf_stored_match got=%0d exp=1", match_a); end total++;
    if (done_a !== 1'b1) begin bad++; $display("FAIL unf_done got=%b exp=1", done_a); end total++;
  endtask

  task automatic test_zero_and_extreme();
    do_start(16'd0);
    if ({done_a, busy_a} !== 2'b10) begin bad++; $display("FAIL zero_done got=%b exp=10", {done_a, busy_a}); end total++;
    if ({match_a, mism_a} !== 32'd0) begin bad++; $display("FAIL zero_counts got=%h exp=0", {match_a, mism_a}); end total++;
    do_start(16'd1);
    push(11'h3FF);
    pop(11'h400);
    if (mism_a !== 16'd1) begin bad++; $display("FAIL ext_mism_a got=%0d exp=1", mism_a); end total++;
    if ({match_b, mism_b} !== {16'd0, 16'd1}) begin bad++; $display("FAIL ext_b got=%h exp=00000001", {match_b, mism_b}); end total++;
    if (ferr_b !== 16'd0) begin bad++; $display("FAIL ext_ferr got=%0d exp=0", ferr_b); end total++;
  endtask

  task automatic test_reset_mid_run();
    do_start(16'd4);
    push(11'd1); push(11'd2); push(11'd3);
    pop(11'd1); pop(11'd2);
    if (match_a !== 16'd2) begin bad++; $display("FAIL mid_match2 got=%0d exp=2", match_a); end total++;
    rst = 1'b1; start = 1'b1; nsamp = 16'd1; evin = 1'b1; vin = 1'b1; din = 11'd3; tick();
    rst = 1'b0; idle_inputs();
    if ({busy_a, done_a, efull_a, ovf_a, unf_a} !== 5'b0) begin bad++; $display("FAIL mid_rst_bits got=%b exp=00000", {busy_a, done_a, efull_a, ovf_a, unf_a}); end total++;
    if ({match_a, mism_a, ferr_a} !== {16'd0, 16'd0, 16'hFFFF}) begin bad++; $display("FAIL mid_rst_counts got=%h exp=00000000ffff", {match_a, mism_a, ferr_a}); end total++;
    do_start(16'd1);
    push(11'd9); pop(11'd9);
    if ({match_a, mism_a} !== {16'd1, 16'd0}) begin bad++; $display("FAIL mid_rerun got=%h exp=00010000", {match_a, mism_a}); end total++;
    if ({done_a, unf_a} !== 2'b10) begin bad++; $display("FAIL mid_rerun_done got=%b exp=10", {done_a, unf_a}); end total++;
  endtask

  task automatic test_back_to_back();
    do_start(16'd2);
    push(11'd4); push(11'd4);
    pop(11'd5);
    if (mism_a !== 16'd1) begin bad++; $display("FAIL b2b_mism got=%0d exp=1", mism_a); end total++;
    do_start(16'd1);
    if ({busy_a, mism_a, ferr_a} !== {1'b1, 16'd0, 16'hFFFF}) begin bad++; $display("FAIL b2b_restart got=%h exp=10000ffff", {busy_a, mism_a, ferr_a}); end total++;
    pop(11'd4);
    if ({unf_a, mism_a} !== {1'b1, 16'd1}) begin bad++; $display("FAIL b2b_fifo_cleared got=%h exp=10001", {unf_a, mism_a}); end total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tolerance();
    test_overflow();
    test_underflow();
    test_zero_and_extreme();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
